// File: rtl/led_chain_pkg.sv
// Shared definitions for the LED chain sequencer: FSM state codes, slave
// handshake codes and default wait limits.
package led_chain_pkg;

  localparam logic [2:0] SEQ_IDLE   = 3'd0;
  localparam logic [2:0] SEQ_CLEAR  = 3'd1;
  localparam logic [2:0] SEQ_ARM    = 3'd2;
  localparam logic [2:0] SEQ_RUN    = 3'd3;
  localparam logic [2:0] SEQ_NEXT   = 3'd4;
  localparam logic [2:0] SEQ_FINISH = 3'd5;
  localparam logic [2:0] SEQ_FAULT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = SEQ_IDLE,
    ST_CLEAR  = SEQ_CLEAR,
    ST_ARM    = SEQ_ARM,
    ST_RUN    = SEQ_RUN,
    ST_NEXT   = SEQ_NEXT,
    ST_FINISH = SEQ_FINISH,
    ST_FAULT  = SEQ_FAULT
  } seq_state_e;

  localparam logic [1:0] DEF_START_CODE = 2'b11;
  localparam logic [3:0] DEF_DONE_STATE = 4'd8;

  localparam int          TMO_CNT_W       = 32;
  localparam logic [31:0] DEF_ARM_TIMEOUT = 32'd16;
  localparam logic [31:0] DEF_RUN_TIMEOUT = 32'd500000000;
  localparam logic [31:0] CLEAR_CYCLES    = 32'd2;

endpackage

// File: rtl/led_chain_sequencer_timeout.sv
// seq_timeout_counter: saturating wait counter with synchronous clear and a
// limit compare; one instance serves the CLEAR, ARM and RUN waits.
module seq_timeout_counter
  import led_chain_pkg::*;
#(
  parameter int CNT_W = TMO_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_d = clr ? '0 : sat_inc(cnt_q);
  end

  // cnt_q is zero on the first cycle after a clear, so hit flags the
  // limit-th cycle spent in the current state.
  assign hit = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, limit};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chain_sequencer.sv
// Master sequencer for a chain of LED sweep slaves: clears, arms and watches
// each slave in turn. Define SEQ_LOOP_EN to repeat the chain until ABORT/FAULT.
module led_chain_sequencer
  import led_chain_pkg::*;
#(
  parameter int          NUM_SLAVES  = 2,
  parameter int          IDX_W       = 3,
  parameter logic [3:0]  DONE_STATE  = DEF_DONE_STATE,
  parameter logic [1:0]  START_CODE  = DEF_START_CODE,
  parameter logic [31:0] ARM_TIMEOUT = DEF_ARM_TIMEOUT,
  parameter logic [31:0] RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [4*NUM_SLAVES-1:0] SLAVE_STATE,
  output logic [2*NUM_SLAVES-1:0] SLAVE_CTRL,
  output logic [NUM_SLAVES-1:0]   SLAVE_RESET,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR,
  output logic [IDX_W-1:0]        ACTIVE_IDX,
  output logic [2:0]              SEQ_STATE
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLAVES - 1);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        active_idx_q, active_idx_d;
  logic [NUM_SLAVES-1:0]   slave_reset_q, slave_reset_d;
  logic [2*NUM_SLAVES-1:0] slave_ctrl_q, slave_ctrl_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [3:0]              act_state;
  logic [TMO_CNT_W-1:0]    tmo_limit;
  logic                    tmo_clr;
  logic                    tmo_hit;

  // Active slave's state, selected with a bounded loop so no index can
  // fall outside the packed bus.
  always_comb begin
    act_state = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (active_idx_q == IDX_W'(i)) begin
        act_state = SLAVE_STATE[4*i +: 4];
      end
    end
  end

  always_comb begin
    tmo_limit = CLEAR_CYCLES;
    case (state_q)
      ST_ARM:  tmo_limit = ARM_TIMEOUT;
      ST_RUN:  tmo_limit = RUN_TIMEOUT;
      default: tmo_limit = CLEAR_CYCLES;
    endcase
  end

  assign tmo_clr = (state_d != state_q);

  seq_timeout_counter #(
    .CNT_W (TMO_CNT_W)
  ) u_tmo (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (tmo_clr),
    .limit (tmo_limit),
    .hit   (tmo_hit)
  );

  always_comb begin
    state_d      = state_q;
    active_idx_d = active_idx_q;
    if (ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && !ABORT && !error_q) begin
            active_idx_d = '0;
            state_d      = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (tmo_hit) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (act_state != 4'd0) state_d = ST_RUN;
          else if (tmo_hit)      state_d = ST_FAULT;
        end
        ST_RUN: begin
          // a completion seen on the timeout cycle still counts as success
          if (act_state == DONE_STATE) state_d = ST_NEXT;
          else if (tmo_hit)            state_d = ST_FAULT;
        end
        ST_NEXT: begin
          if (active_idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            active_idx_d = active_idx_q + 1'b1;
            state_d      = ST_CLEAR;
          end
        end
        ST_FINISH: begin
          active_idx_d = '0;
`ifdef SEQ_LOOP_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_IDLE;
`endif
        end
        ST_FAULT: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered values line
  // up with SEQ_STATE; only the active slave is ever released or driven.
  always_comb begin
    slave_reset_d = '1;
    slave_ctrl_d  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (active_idx_d == IDX_W'(i)) begin
        if (state_d == ST_ARM) begin
          slave_reset_d[i]       = 1'b0;
          slave_ctrl_d[2*i +: 2] = START_CODE;
        end else if (state_d == ST_RUN) begin
          slave_reset_d[i] = 1'b0;
        end
      end
    end
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FINISH);
    error_d = error_q | (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      active_idx_q  <= '0;
      slave_reset_q <= '1;
      slave_ctrl_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_idx_q  <= active_idx_d;
      slave_reset_q <= slave_reset_d;
      slave_ctrl_q  <= slave_ctrl_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign SLAVE_CTRL  = slave_ctrl_q;
  assign SLAVE_RESET = slave_reset_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;
  assign ACTIVE_IDX  = active_idx_q;
  assign SEQ_STATE   = state_q;

endmodule
